// File: rtl/snn_pkg.sv
// Shared definitions for the spike-rate decoder: FSM states, default widths
// and the saturation limit helper.
package snn_pkg;

  localparam int WIN_W_DEF = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter
  import snn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike onsets over fixed 2^WIN_W-cycle windows and tracks the last
// inter-spike interval; results are handed off through a valid/ready latch.
//
// state    | meaning
// ST_IDLE  | decoding disabled, all window/ISI bookkeeping held at zero
// ST_COUNT | counting window cycles, onsets and inter-spike intervals
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  input  logic             ready,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             valid,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [WIN_W-1:0] WIN_LAST = '1;

  state_e           state_q, state_d;
  logic             spike_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] last_isi_q, last_isi_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0] isi_q, isi_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             active, onset, win_final;
  logic [CNT_W-1:0] onset_cnt, isi_cnt;
  logic [CNT_W-1:0] rate_pub, isi_plus1;

  // Dropping en in COUNT counts as leaving the window in that same cycle.
  assign active    = (state_q == ST_COUNT) && en;
  assign onset     = spike & ~spike_q;
  assign win_final = active && (win_q == WIN_LAST);

  sat_counter #(.W(CNT_W)) u_onset_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (active & onset),
    .clr   (~active | win_final),
    .count (onset_cnt)
  );

  sat_counter #(.W(CNT_W)) u_isi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (active),
    .clr   (~active | onset),
    .count (isi_cnt)
  );

  assign rate_pub  = (onset && (onset_cnt != CNT_MAX)) ? onset_cnt + CNT_W'(1) : onset_cnt;
  assign isi_plus1 = (isi_cnt != CNT_MAX) ? isi_cnt + CNT_W'(1) : isi_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en)  state_d = ST_COUNT;
      ST_COUNT: if (!en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_d      = '0;
    seen_d     = 1'b0;
    last_isi_d = '0;
    if (active) begin
      win_d      = win_q + WIN_W'(1);
      seen_d     = seen_q;
      last_isi_d = last_isi_q;
      if (onset) begin
        seen_d = 1'b1;
        if (seen_q) last_isi_d = isi_plus1;
      end
    end
  end

  // A result still waiting for ready is kept; the newer one is dropped.
  always_comb begin
    rate_d    = rate_q;
    isi_d     = isi_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (win_final) begin
      if (!valid_q || ready) begin
        rate_d  = rate_pub;
        isi_d   = last_isi_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      spike_q    <= 1'b0;
      win_q      <= '0;
      seen_q     <= 1'b0;
      last_isi_q <= '0;
      rate_q     <= '0;
      isi_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      spike_q    <= spike;
      win_q      <= win_d;
      seen_q     <= seen_d;
      last_isi_q <= last_isi_d;
      rate_q     <= rate_d;
      isi_q      <= isi_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rate    = rate_q;
  assign isi     = isi_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: main decoder at WIN_W=4/CNT_W=8 checked through a result
// scoreboard, plus a WIN_W=6/CNT_W=4 instance for rate saturation.
module tb_spike_rate_decoder;
  import snn_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en, spike, ready, clr_overrun;
  logic [7:0] rate, isi;
  logic       valid, overrun;

  logic       en2, spike2, ready2, clr_overrun2;
  logic [3:0] rate2, isi2;
  logic       valid2, overrun2;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  spike_rate_decoder #(.WIN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .ready(ready),
    .clr_overrun(clr_overrun), .rate(rate), .isi(isi), .valid(valid),
    .overrun(overrun)
  );

  spike_rate_decoder #(.WIN_W(6), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .spike(spike2), .ready(ready2),
    .clr_overrun(clr_overrun2), .rate(rate2), .isi(isi2), .valid(valid2),
    .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Consumer side: a result is taken in any cycle with valid and ready high.
  task automatic check_out();
    logic [15:0] e;
    if (valid && ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_publish: observed rate=%0d isi=%0d expected no result", rate, isi);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_rate", {24'd0, rate}, {24'd0, e[15:8]});
        chk("sb_isi",  {24'd0, isi},  {24'd0, e[7:0]});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_window(input logic [15:0] pat);
    for (int c = 0; c < 16; c++) begin
      spike = pat[c];
      tick();
    end
    spike = 1'b0;
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  initial begin
    logic [15:0] pat;
    int n;

    rst_n = 1'b0; en = 1'b1; spike = 1'b0; ready = 1'b1; clr_overrun = 1'b0;
    en2 = 1'b0; spike2 = 1'b0; ready2 = 1'b1; clr_overrun2 = 1'b0;
    #2;
    chk("rst_rate",    {24'd0, rate}, 32'd0);
    chk("rst_isi",     {24'd0, isi},  32'd0);
    chk("rst_valid",   {31'd0, valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // alternating spikes starting in window cycle 0
    repeat (3) sb.push_back({8'd8, 8'd2});
    repeat (3) run_window(16'h5555);

    // spike held high from window cycle 0
    restart();
    sb.push_back({8'd1, 8'd0});
    sb.push_back({8'd0, 8'd0});
    sb.push_back({8'd0, 8'd0});
    spike = 1'b1;
    repeat (48) tick();
    spike = 1'b0;

    // abort at window cycle 7, then measure latency of the next result
    restart();
    repeat (7) tick();
    en = 1'b0;
    tick();
    chk("abort_state", {31'd0, dut.state_q}, {31'd0, ST_IDLE});
    chk("abort_valid", {31'd0, valid}, 32'd0);
    en = 1'b1;
    tick();
    pat = 16'h8438;
    sb.push_back({8'd3, 8'd5});
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      spike = (k <= 16) ? pat[k-1] : 1'b0;
      tick();
      if (valid) begin
        n = k;
        break;
      end
    end
    spike = 1'b0;
    chk("restart_latency", n, 32'd16);

    // back-pressure across two window ends
    restart();
    sb.push_back({8'd8, 8'd2});
    ready = 1'b0;
    run_window(16'h5555);
    chk("hold1_valid",   {31'd0, valid}, 32'd1);
    chk("hold1_rate",    {24'd0, rate}, 32'd8);
    chk("hold1_isi",     {24'd0, isi},  32'd2);
    chk("hold1_overrun", {31'd0, overrun}, 32'd0);
    run_window(16'h0020);
    chk("hold2_valid",   {31'd0, valid}, 32'd1);
    chk("hold2_rate",    {24'd0, rate}, 32'd8);
    chk("hold2_isi",     {24'd0, isi},  32'd2);
    chk("hold2_overrun", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("clr_overrun", {31'd0, overrun}, 32'd0);
    chk("clr_rate",    {24'd0, rate}, 32'd8);
    ready = 1'b1;
    check_out();
    tick();
    chk("accept_valid", {31'd0, valid}, 32'd0);

    // asynchronous reset mid-window with a held result and overrun set
    ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid) break;
      tick();
    end
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    repeat (16) tick();
    chk("pre_rst_overrun", {31'd0, overrun}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid",   {31'd0, valid}, 32'd0);
    chk("async_rate",    {24'd0, rate}, 32'd0);
    chk("async_isi",     {24'd0, isi},  32'd0);
    chk("async_overrun", {31'd0, overrun}, 32'd0);
    chk("async_state",   {31'd0, dut.state_q}, {31'd0, ST_IDLE});
    rst_n = 1'b1;
    en = 1'b0;
    ready = 1'b1;

    // saturation on the narrow instance
    en2 = 1'b1;
    tick();
    for (int c = 0; c < 64; c++) begin
      spike2 = ((c % 2) == 0);
      tick();
    end
    spike2 = 1'b0;
    chk("sat_valid", {31'd0, valid2}, 32'd1);
    chk("sat_rate",  {28'd0, rate2}, 32'd15);
    chk("sat_isi",   {28'd0, isi2},  32'd2);

    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WIN_W, default 6: the counting window is 2^WIN_W cycles long.
REQ-002 Parameter CNT_W, default 8: width of the rate and isi outputs.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  decode enable; 0 aborts the current window and holds the FSM in IDLE.
REQ-006 spike  input  1  level spike from a neuron; may stay high for several cycles.
REQ-007 rate  output  CNT_W  spike-onset count of the last completed window, saturating.
REQ-008 isi  output  CNT_W  last inter-spike interval in cycles, saturating; 0 if fewer than 2 onsets.
REQ-009 valid  output  1  rate and isi hold a result that has not yet been accepted.
REQ-010 ready  input  1  consumer accepts the result in any cycle where valid and ready are both 1.
REQ-011 overrun  output  1  sticky flag: a window result was dropped.
REQ-012 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-013 A registered copy spike_q SHALL update every cycle; onset = spike & ~spike_q, so no false onset occurs when en rises while spike is already high.
REQ-014 The FSM SHALL have two states, IDLE and COUNT: IDLE->COUNT on en=1; COUNT->IDLE on en=0.
REQ-015 The first counting cycle SHALL be the cycle after en is sampled 1 in IDLE.
REQ-016 Entering IDLE SHALL clear the window counter, the onset counter, the ISI counter, the last ISI and the seen-onset flag; the partial window is discarded and nothing is published.
REQ-017 In COUNT, the window counter SHALL increment each cycle and wrap from 2^WIN_W-1 to 0.
REQ-018 In COUNT, each onset SHALL add 1 to the onset count, saturating at 2^CNT_W-1.
REQ-019 In the final window cycle (counter = 2^WIN_W-1), the published rate SHALL include that cycle's onset (saturated), and the onset count SHALL restart at 0.
REQ-020 ISI counting SHALL work as follows:
- The ISI counter increments each COUNT cycle, saturating at 2^CNT_W-1.
- On an onset with seen-onset=1, last ISI <= ISI counter + 1 (saturated).
- On every onset, seen-onset <= 1 and the ISI counter <= 0.
- ISI measurement spans window boundaries.
REQ-021 The published isi SHALL be last ISI including any onset in the final cycle, and 0 until two onsets have occurred since entering COUNT.
REQ-022 Publish latency: rate, isi and valid SHALL update on the clock edge ending the final window cycle.
REQ-023 A publish SHALL load rate and isi and set valid when valid=0, or when valid=1 and ready=1 in the same cycle.
REQ-024 A publish while valid=1 and ready=0 SHALL leave rate and isi unchanged, keep valid=1 and set overrun.
REQ-025 Without a publish, valid SHALL clear on the edge following a cycle where valid=1 and ready=1.
REQ-026 rate and isi SHALL be stable while valid=1 and ready=0.
REQ-027 overrun SHALL clear on clr_overrun=1; if a set and a clear coincide, the set wins.
REQ-028 ready SHALL be ignored while valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and clear spike_q, all counters, seen-onset, last ISI, rate=0, isi=0, valid=0 and overrun=0, independent of clk.
REQ-030 Reset release SHALL take effect synchronously on clk, with en sampled from the first edge after release.

Structure
REQ-031 Shared package snn_pkg SHALL hold the FSM state enumeration, the WIN_W/CNT_W defaults and a saturating-max constant function.
REQ-032 One sub-module, sat_counter (width parameter; inc, clr, count), SHALL be instantiated for both the onset counter and the ISI counter.

Verification (WIN_W=4, CNT_W=8 unless stated; en=1 from reset release, ready=1)
REQ-033 spike alternates 1,0 starting high in window cycle 0 -> every window publishes rate=8, isi=2.
REQ-034 spike held high throughout -> first window rate=1, isi=0; later windows rate=0, isi=0.
REQ-035 ready=0 across two window ends -> first result held with valid=1, overrun=1 after the second end; clr_overrun pulse -> overrun=0, rate unchanged.
REQ-036 en dropped at window cycle 7 -> no publish and state IDLE; re-enable -> next result after exactly 16 counting cycles.
REQ-037 WIN_W=6, CNT_W=4, alternating spike -> rate=15 (saturated), isi=2.
REQ-038 rst_n pulsed low mid-window between clock edges -> valid, rate, isi and overrun read 0 before the next edge.
